// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative MIPS-style HI/LO multiply/divide unit (1 bit/cycle).
//            Divider is compiled in only when MULDIV_DIV_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] work_q, work_d;
    logic        neg_lo_q, neg_lo_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        w_signed;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [63:0] w_mul_res;

    assign w_signed = ~op[0];
    assign w_a_abs  = (w_signed && a[31]) ? (~a + 32'd1) : a;
    assign w_b_abs  = (w_signed && b[31]) ? (~b + 32'd1) : b;

    // work_q = {partial product, remaining multiplier bits}; shift right each step
    assign w_mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign w_mul_next = {w_mul_sum, work_q[31:1]};
    assign w_mul_res  = neg_lo_q ? (~w_mul_next + 64'd1) : w_mul_next;

`ifdef MULDIV_DIV_EN
    logic        neg_hi_q, neg_hi_d;
    logic        bz_q, bz_d;
    logic [32:0] w_div_sh;
    logic        w_div_ge;
    logic [31:0] w_div_rem;
    logic [63:0] w_div_next;
    logic [31:0] w_div_quo;
    logic [31:0] w_div_lo;
    logic [31:0] w_div_hi;

    // work_q = {partial remainder, dividend shifting out / quotient shifting in}
    assign w_div_sh   = work_q[63:31];
    assign w_div_ge   = (w_div_sh >= {1'b0, opnd_q});
    assign w_div_rem  = w_div_ge ? (w_div_sh[31:0] - opnd_q) : w_div_sh[31:0];
    assign w_div_next = {w_div_rem, work_q[30:0], w_div_ge};
    assign w_div_quo  = w_div_next[31:0];
    // Divide-by-zero naturally yields all-ones quotient; keep it unsigned
    assign w_div_lo   = (neg_lo_q && !bz_q) ? (~w_div_quo + 32'd1) : w_div_quo;
    assign w_div_hi   = neg_hi_q ? (~w_div_rem + 32'd1) : w_div_rem;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        work_d   = work_q;
        neg_lo_d = neg_lo_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULDIV_DIV_EN
        neg_hi_d = neg_hi_q;
        bz_d     = bz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (we_hi) hi_d = wdata;
                if (we_lo) lo_d = wdata;
                if (start) begin
                    cnt_d = 6'd0;
                    if (!op[1]) begin
                        state_d  = S_MUL;
                        opnd_d   = w_a_abs;
                        work_d   = {32'd0, w_b_abs};
                        neg_lo_d = w_signed & (a[31] ^ b[31]);
                    end else begin
`ifdef MULDIV_DIV_EN
                        state_d  = S_DIV;
                        opnd_d   = w_b_abs;
                        work_d   = {32'd0, w_a_abs};
                        neg_lo_d = w_signed & (a[31] ^ b[31]);
                        neg_hi_d = w_signed & a[31];
                        bz_d     = (b == 32'd0);
`else
                        done_d   = 1'b1;
`endif
                    end
                end
            end
            S_MUL: begin
                work_d = w_mul_next;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    {hi_d, lo_d} = w_mul_res;
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                work_d = w_div_next;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    hi_d    = w_div_hi;
                    lo_d    = w_div_lo;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            opnd_q   <= 32'd0;
            work_q   <= 64'd0;
            neg_lo_q <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
`ifdef MULDIV_DIV_EN
            neg_hi_q <= 1'b0;
            bz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            work_q   <= work_d;
            neg_lo_q <= neg_lo_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULDIV_DIV_EN
            neg_hi_q <= neg_hi_d;
            bz_q     <= bz_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit: arithmetic reference model,
//            per-cycle compare, directed cases and randomized traffic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // {hi,lo} straight from the arithmetic definition of each operation
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        int qx, qy;
        case (o)
            2'b00: begin
                sx = {{32{x[31]}}, x};
                sy = {{32{y[31]}}, y};
                return sx * sy;
            end
            2'b01: return {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'b11) return {x % y, x / y};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qx = x;
                qy = y;
                return {32'(qx % qy), 32'(qx / qy)};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Cycle-level reference: countdown to completion plus pending result
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_rem  = 0;
    bit          m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_rem  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else begin
                if (we_hi) m_hi <= wdata;
                if (we_lo) m_lo <= wdata;
                if (start) begin
                    if (!op[1] || DIV_EN) begin
                        m_pend <= ref_result(op, a, b);
                        m_rem  <= 32;
                    end else begin
                        m_done <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_rem != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("hi",   64'(hi),   64'(m_hi));
            chk("lo",   64'(lo),   64'(m_lo));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic mt(input logic [31:0] d);
        we_hi = 1'b1;
        we_lo = 1'b1;
        wdata = d;
        step();
        we_hi = 1'b0;
        we_lo = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);

        chk("model_mult",  ref_result(2'b00, 32'hFFFF_FFFD, 32'd7),          64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_multu", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF),  64'hFFFF_FFFE_0000_0001);
        chk("model_div",   ref_result(2'b10, 32'hFFFF_FFF9, 32'd2),          64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_divu0", ref_result(2'b11, 32'h0000_1234, 32'd0),          64'h0000_1234_FFFF_FFFF);
        chk("model_ovf",   ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF),  64'h0000_0000_8000_0000);

        rst = 1'b0;
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(n);
        chk("mult_latency", 64'(n), 64'd32);
        chk("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        step();
        chk("mult_done_pulse", 64'(done), 64'd0);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("multu_latency", 64'(n), 64'd32);
        chk("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);

`ifdef MULDIV_DIV_EN
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_latency", 64'(n), 64'd32);
        chk("div_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("div_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        issue(2'b11, 32'h0000_1234, 32'd0);
        wait_done(n);
        chk("divu0_latency", 64'(n), 64'd32);
        chk("divu0_hi", 64'(hi), 64'h0000_0000_0000_1234);
        chk("divu0_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("ovf_hi", 64'(hi), 64'd0);
        chk("ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
`else
        mt(32'h55);
        issue(2'b10, 32'd10, 32'd3);
        chk("nodiv_done", 64'(done), 64'd1);
        chk("nodiv_busy", 64'(busy), 64'd0);
        chk("nodiv_hi",   64'(hi),   64'h55);
        chk("nodiv_lo",   64'(lo),   64'h55);
        step();
        chk("nodiv_done_pulse", 64'(done), 64'd0);
`endif

        // start and MTLO while busy are both dropped
        mt(32'd0);
        issue(2'b01, 32'd5, 32'd6);
        repeat (3) step();
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        we_lo = 1'b1;
        wdata = 32'hAA;
        step();
        we_lo = 1'b0;
        wait_done(n);
        chk("ignore_hi", 64'(hi), 64'd0);
        chk("ignore_lo", 64'(lo), 64'd30);
        step();
        chk("ignore_no_restart", 64'(busy), 64'd0);

        // reset mid-operation aborts with no trailing done
        issue(2'b00, 32'h0000_1234, 32'hFFFF_FFFB);
        repeat (9) step();
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi",   64'(hi),   64'd0);
        chk("abort_lo",   64'(lo),   64'd0);
        step();
        rst = 1'b0;
        issue(2'b01, 32'd2, 32'd3);
        wait_done(n);
        chk("post_rst_latency", 64'(n), 64'd32);
        chk("post_rst_hi", 64'(hi), 64'd0);
        chk("post_rst_lo", 64'(lo), 64'd6);

        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 5) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            we_hi = ($urandom_range(0, 7) == 0);
            we_lo = ($urandom_range(0, 7) == 0);
            wdata = $urandom;
            rst   = ($urandom_range(0, 399) == 0);
            step();
        end
        start = 1'b0;
        we_hi = 1'b0;
        we_lo = 1'b0;
        rst   = 1'b0;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
        $fatal(1);
    end

endmodule

`default_nettype wire
